// File: rtl/rvfpm_issue_driver.sv
// rvfpm_issue_driver: queues RV32 FP instructions, issues them to an FPU pipeline and
// tracks in-flight destinations. Define RVFPM_HAZARD_CHECK_EN to enable RAW-hazard stalls.
module rvfpm_issue_driver #(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        halt,
  output logic        enable,
  output logic [31:0] instruction,
  output logic        issue_valid,
  output logic        hazard_stall,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [4:0]  inflight_cnt,
  output logic [31:0] issue_cnt,
  output logic [15:0] illegal_cnt
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LAST = PIPELINE_STAGES - 1;
  localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];
`ifdef RVFPM_HAZARD_CHECK_EN
  localparam bit HAZARD_EN = 1'b1;
`else
  localparam bit HAZARD_EN = 1'b0;
`endif

  logic [31:0]                mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [AW:0]                count;
  logic                       q_empty, q_full;
  logic                       do_push, do_pop, do_issue, do_drop;
  logic [31:0]                head;
  logic                       legal, writes_rd, use_rs1, use_rs2, use_rs3, raw_hit;
  logic [RW-1:0]              rs1, rs2, rs3;
  logic [PIPELINE_STAGES-1:0] sh_valid, sh_wr;
  logic [4:0]                 sh_rd [PIPELINE_STAGES];

  assign head     = mem[rd_ptr];
  assign q_empty  = (count == '0);
  assign q_full   = (count == DEPTH_CNT);
  assign in_ready = rst && !q_full;
  assign do_push  = in_valid && in_ready;

  assign rs1 = head[15 +: RW];
  assign rs2 = head[20 +: RW];
  assign rs3 = head[27 +: RW];

  always_comb begin
    legal     = 1'b1;
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rs3   = 1'b0;
    case (head[6:0])
      7'b0000111: writes_rd = 1'b1;
      7'b0100111: use_rs2 = 1'b1;
      7'b1010011: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rs3   = 1'b1;
        writes_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Register indices alias modulo NUM_REGS when the file is smaller than 32 entries
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < PIPELINE_STAGES; i++) begin
      if (sh_valid[i] && sh_wr[i]) begin
        if ((use_rs1 && sh_rd[i][RW-1:0] == rs1) ||
            (use_rs2 && sh_rd[i][RW-1:0] == rs2) ||
            (use_rs3 && sh_rd[i][RW-1:0] == rs3))
          raw_hit = 1'b1;
      end
    end
  end

  assign hazard_stall = HAZARD_EN && !q_empty && legal && raw_hit;
  assign do_issue     = !q_empty && legal && enable && !hazard_stall;
  assign do_drop      = !q_empty && !legal && enable;
  assign do_pop       = do_issue || do_drop;

  always_comb begin
    inflight_cnt = 5'd0;
    for (int i = 0; i < PIPELINE_STAGES; i++)
      inflight_cnt = inflight_cnt + {4'd0, sh_valid[i]};
  end

  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      enable       <= 1'b0;
      instruction  <= '0;
      issue_valid  <= 1'b0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      issue_cnt    <= '0;
      illegal_cnt  <= '0;
      sh_valid     <= '0;
      sh_wr        <= '0;
      for (int i = 0; i < PIPELINE_STAGES; i++) sh_rd[i] <= '0;
    end else begin
      enable      <= !halt;
      instruction <= do_issue ? head : 32'd0;
      issue_valid <= do_issue;
      if (do_issue) issue_cnt <= issue_cnt + 32'd1;
      if (do_drop && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
      // Shadow tracks the FPU pipeline exactly, so it freezes whenever the FPU does
      if (enable) begin
        retire_valid <= sh_valid[LAST];
        retire_rd    <= sh_valid[LAST] ? sh_rd[LAST] : 5'd0;
        for (int i = LAST; i > 0; i--) begin
          sh_valid[i] <= sh_valid[i-1];
          sh_wr[i]    <= sh_wr[i-1];
          sh_rd[i]    <= sh_rd[i-1];
        end
        sh_valid[0] <= do_issue;
        sh_wr[0]    <= do_issue && writes_rd;
        sh_rd[0]    <= do_issue ? head[11:7] : 5'd0;
      end else begin
        retire_valid <= 1'b0;
        retire_rd    <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_rvfpm_issue_driver.sv
// Directed bench for rvfpm_issue_driver: reset, issue/retire latency, RAW hazard,
// illegal drop, halt backpressure, steady stream and mid-flight reset.
module tb_rvfpm_issue_driver;
  logic        ck = 1'b0;
  logic        rst, in_valid, halt;
  logic [31:0] in_instr;
  logic        in_ready, enable, issue_valid, hazard_stall, retire_valid;
  logic [31:0] instruction, issue_cnt;
  logic [4:0]  retire_rd, inflight_cnt;
  logic [15:0] illegal_cnt;
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FLW3 = 32'h00002187;
  localparam logic [31:0] FADD = 32'h004182D3;
  localparam logic [31:0] ILL  = 32'h00000033;

  always #5 ck = ~ck;

  rvfpm_issue_driver dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .halt(halt), .enable(enable), .instruction(instruction), .issue_valid(issue_valid),
    .hazard_stall(hazard_stall), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .inflight_cnt(inflight_cnt), .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt)
  );

  function automatic logic [31:0] flw(input int r);
    return 32'h00002007 | (32'(r & 31) << 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge ck);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; halt = 1'b0; in_instr = '0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_enable", enable, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_inflight", inflight_cnt, 0);
    chk("rst_issue_cnt", issue_cnt, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    step(); step();
    rst = 1'b1;
    step();
    chk("run_enable", enable, 1);
    chk("run_in_ready", in_ready, 1);

    // single FLW: issue one cycle after push, retire four cycles after issue
    in_valid = 1'b1; in_instr = FLW3;
    step();
    in_valid = 1'b0;
    chk("t1_no_early_issue", issue_valid, 0);
    step();
    chk("t1_issue_valid", issue_valid, 1);
    chk("t1_instruction", instruction, FLW3);
    chk("t1_inflight", inflight_cnt, 1);
    chk("t1_issue_cnt", issue_cnt, 1);
    step(); step(); step();
    chk("t1_no_early_retire", retire_valid, 0);
    chk("t1_bubble", instruction, 0);
    step();
    chk("t1_retire_valid", retire_valid, 1);
    chk("t1_retire_rd", retire_rd, 3);
    chk("t1_inflight_after", inflight_cnt, 0);
    step();
    chk("t1_retire_pulse", retire_valid, 0);

    // FLW f3 followed by FADD f5,f3,f4
    in_valid = 1'b1; in_instr = FLW3;
    step();
    in_instr = FADD;
    step();
    in_valid = 1'b0;
    chk("t2_flw_issue", instruction, FLW3);
`ifdef RVFPM_HAZARD_CHECK_EN
    chk("t2_hazard_n", hazard_stall, 1);
    step(); step(); step();
    chk("t2_hazard_n3", hazard_stall, 1);
    chk("t2_stalled", issue_valid, 0);
    step();
    chk("t2_flw_retire", retire_valid, 1);
    chk("t2_hazard_clear", hazard_stall, 0);
    chk("t2_not_yet", issue_valid, 0);
    step();
    chk("t2_fadd_issue", issue_valid, 1);
    chk("t2_fadd_instr", instruction, FADD);
    step(); step(); step(); step();
    chk("t2_fadd_retire", retire_valid, 1);
    chk("t2_fadd_rd", retire_rd, 5);
`else
    chk("t2_no_hazard", hazard_stall, 0);
    step();
    chk("t2_fadd_issue", issue_valid, 1);
    chk("t2_fadd_instr", instruction, FADD);
    chk("t2_inflight2", inflight_cnt, 2);
    step(); step(); step();
    chk("t2_flw_retire", retire_rd, 3);
    step();
    chk("t2_fadd_retire", retire_valid, 1);
    chk("t2_fadd_rd", retire_rd, 5);
`endif
    step(); step();
    chk("t2_drained", inflight_cnt, 0);
    chk("t2_issue_cnt", issue_cnt, 3);

    // unsupported opcode dropped, following FLW issues normally
    in_valid = 1'b1; in_instr = ILL;
    step();
    in_instr = FLW3;
    step();
    in_valid = 1'b0;
    chk("t3_no_issue", issue_valid, 0);
    chk("t3_illegal_cnt", illegal_cnt, 1);
    step();
    chk("t3_next_issue", issue_valid, 1);
    chk("t3_next_instr", instruction, FLW3);
    chk("t3_issue_cnt", issue_cnt, 4);
    step(); step(); step(); step(); step();
    chk("t3_drained", inflight_cnt, 0);

    // halt with one entry in flight, then five back-to-back pushes
    in_valid = 1'b1; in_instr = FLW3;
    step();
    in_valid = 1'b0;
    step();
    halt = 1'b1;
    step();
    chk("t4_enable_low", enable, 0);
    chk("t4_inflight", inflight_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = flw(i + 1);
      chk("t4_in_ready", in_ready, (i < 4) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    chk("t4_full", in_ready, 0);
    chk("t4_no_issue", issue_valid, 0);
    step(); step(); step();
    chk("t4_frozen", inflight_cnt, 1);
    chk("t4_no_retire", retire_valid, 0);
    chk("t4_still_no_issue", issue_valid, 0);
    halt = 1'b0;
    step();
    chk("t4_enable_back", enable, 1);
    chk("t4_no_issue_yet", issue_valid, 0);
    step();
    chk("t4_resume_issue", instruction, flw(1));
    chk("t4_resume_inflight", inflight_cnt, 2);
    step(); step();
    chk("t4_resume_retire", retire_valid, 1);
    chk("t4_resume_rd", retire_rd, 3);
    step(); step(); step(); step(); step(); step(); step(); step();
    chk("t4_drained", inflight_cnt, 0);
    chk("t4_issue_cnt", issue_cnt, 9);

    // continuous independent stream
    for (int j = 0; j < 12; j++) begin
      in_valid = 1'b1; in_instr = flw(j);
      step();
      if (j >= 5) begin
        chk("t5_inflight", inflight_cnt, 4);
        chk("t5_issue", instruction, flw(j - 1));
        chk("t5_retire", retire_valid, 1);
        chk("t5_retire_rd", retire_rd, 32'(j - 5));
      end
    end
    in_valid = 1'b0;
    step(); step(); step(); step(); step(); step(); step();
    chk("t5_drained", inflight_cnt, 0);
    chk("t5_issue_cnt", issue_cnt, 21);

    // reset with three FLWs in flight
    in_valid = 1'b1; in_instr = flw(1);
    step();
    in_instr = flw(2);
    step();
    in_instr = flw(3);
    step();
    in_valid = 1'b0;
    step();
    chk("t6_inflight3", inflight_cnt, 3);
    chk("t6_issue_cnt", issue_cnt, 24);
    #2 rst = 1'b0;
    #1;
    chk("t6_enable", enable, 0);
    chk("t6_instruction", instruction, 0);
    chk("t6_issue_valid", issue_valid, 0);
    chk("t6_inflight", inflight_cnt, 0);
    chk("t6_issue_cnt0", issue_cnt, 0);
    chk("t6_illegal_cnt0", illegal_cnt, 0);
    chk("t6_in_ready", in_ready, 0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_no_retire", retire_valid, 0);
      chk("t6_inflight_zero", inflight_cnt, 0);
    end
    chk("t6_enable_back", enable, 1);
    chk("t6_issue_cnt_after", issue_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
